// File: rtl/instr_fetch_buffer_if.sv
// Fetch buffer bus interface: instruction-memory read port, redirect input
// and the decode-side valid/ready stream. The master side is the fetch buffer.
interface instr_fetch_buffer_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        dec_ready;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pcplus4;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  pc_redirect,
        input  pc_target,
        input  dec_ready,
        output dec_valid,
        output dec_instr,
        output dec_pc,
        output dec_pcplus4
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output pc_redirect,
        output pc_target,
        output dec_ready,
        input  dec_valid,
        input  dec_instr,
        input  dec_pc,
        input  dec_pcplus4
    );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: PC register driving a combinational-read
// instruction memory, feeding a 2-entry {instr, pc} FIFO towards decode.
// Decode outputs come only from registered FIFO entries (one-cycle latency).
// Optional feature: define FETCH_STALLCNT_EN to add the stall_cnt output,
// a free-running count of cycles where decode holds off a valid entry.
module instr_fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_fetch_buffer_if.master   bus
`ifdef FETCH_STALLCNT_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);

    logic [31:0] pc;
    logic [1:0]  count;
    logic        head;
    logic        tail;
    logic [31:0] instr_mem [2];
    logic [31:0] pc_mem    [2];
    logic        pop;
    logic        push;

    assign bus.dec_valid   = (count != 2'd0);
    assign bus.dec_instr   = instr_mem[head];
    assign bus.dec_pc      = pc_mem[head];
    assign bus.dec_pcplus4 = pc_mem[head] + 32'd4;
    assign bus.imem_addr   = pc;

    // A redirect cancels both the pop and the push of the current edge
    assign pop  = bus.dec_valid & bus.dec_ready;
    assign push = !bus.pc_redirect && ((count < 2'd2) || pop);

    // Fetch PC: jumps to the word-aligned target on redirect, else advances per push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (bus.pc_redirect) begin
            pc <= {bus.pc_target[31:2], 2'b00};
        end else if (push) begin
            pc <= pc + 32'd4;
        end
    end

    // Occupancy and head/tail pointers; a redirect flushes the whole FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else if (bus.pc_redirect) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
            if (pop) begin
                head <= ~head;
            end
            if (push) begin
                tail <= ~tail;
            end
        end
    end

    // FIFO payload storage: the fetched word and its PC are written at the tail
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_mem[0] <= 32'd0;
            instr_mem[1] <= 32'd0;
            pc_mem[0]    <= 32'd0;
            pc_mem[1]    <= 32'd0;
        end else if (push) begin
            instr_mem[tail] <= bus.imem_rdata;
            pc_mem[tail]    <= pc;
        end
    end

`ifdef FETCH_STALLCNT_EN
    // Counts edges where a valid head entry is refused by decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (bus.dec_valid && !bus.dec_ready) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Testbench for instr_fetch_buffer: directed scenarios followed by random
// traffic, checked per cycle against a queue-based reference model through
// a scoreboard. Build with FETCH_STALLCNT_EN defined to also check stall_cnt.
module tb_instr_fetch_buffer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] stall;
    } exp_t;

    logic clk;
    logic rst;
    instr_fetch_buffer_if bus ();
`ifdef FETCH_STALLCNT_EN
    logic [31:0] stall_cnt;
`endif

    int tests  = 0;
    int failed = 0;

    entry_t      model_q [$];
    logic [31:0] model_pc;
    logic [31:0] model_stall;
    exp_t        exp_q [$];

    // Memory image: every word is its own address xor a fixed key
    assign bus.imem_rdata = bus.imem_addr ^ KEY;

    instr_fetch_buffer #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_STALLCNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        model_pc    = RESET_PC;
        model_stall = 32'd0;
    endtask

    // Drives one cycle of inputs: records what the DUT must show during this
    // cycle, then advances the reference model across the coming edge
    task automatic applyStimulus(input logic ready, input logic redirect,
                                 input logic [31:0] target);
        exp_t e;
        bus.dec_ready   = ready;
        bus.pc_redirect = redirect;
        bus.pc_target   = target;

        e.valid = (model_q.size() != 0);
        e.instr = e.valid ? model_q[0].instr : 32'd0;
        e.pc    = e.valid ? model_q[0].pc    : 32'd0;
        e.addr  = model_pc;
        e.stall = model_stall;
        exp_q.push_back(e);

        if (e.valid && !ready) begin
            model_stall = model_stall + 32'd1;
        end
        if (redirect) begin
            model_q.delete();
            model_pc = target & 32'hFFFF_FFFC;
        end else begin
            if (e.valid && ready) begin
                void'(model_q.pop_front());
            end
            if (model_q.size() < 2) begin
                model_q.push_back('{instr: model_pc ^ KEY, pc: model_pc});
                model_pc = model_pc + 32'd4;
            end
        end

        @(posedge clk);
        #1;
    endtask

    // Monitor: compares each cycle's DUT outputs with the scoreboard entry
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("dec_valid", {31'd0, bus.dec_valid}, {31'd0, e.valid});
                checkOutput("imem_addr", bus.imem_addr, e.addr);
                if (e.valid) begin
                    checkOutput("dec_instr", bus.dec_instr, e.instr);
                    checkOutput("dec_pc", bus.dec_pc, e.pc);
                    checkOutput("dec_pcplus4", bus.dec_pcplus4, e.pc + 32'd4);
                end
`ifdef FETCH_STALLCNT_EN
                checkOutput("stall_cnt", stall_cnt, e.stall);
`endif
            end
        end
    end

    // Main stimulus sequence
    initial begin
        logic        r;
        logic        d;
        logic [31:0] t;

        rst             = 1'b1;
        bus.dec_ready   = 1'b0;
        bus.pc_redirect = 1'b0;
        bus.pc_target   = 32'd0;
        modelReset();

        #2;
        checkOutput("reset dec_valid", {31'd0, bus.dec_valid}, 32'd0);
        checkOutput("reset dec_instr", bus.dec_instr, 32'd0);
        checkOutput("reset dec_pc", bus.dec_pc, 32'd0);
        checkOutput("reset dec_pcplus4", bus.dec_pcplus4, 32'd4);
        checkOutput("reset imem_addr", bus.imem_addr, RESET_PC);

        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming with decode always ready
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'd0);

        // Back-pressure: FIFO fills and the fetch address freezes
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'd0);

        // Redirect with a full FIFO and decode ready
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0103);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'd0);

        // Redirect to the top word so the PC wraps to zero
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'd0);

        // Seven stalled edges with a valid head, then drain
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0);

        // Asynchronous reset between edges while the FIFO is full
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'd0);
        #6;
        rst = 1'b1;
        #1;
        checkOutput("async rst dec_valid", {31'd0, bus.dec_valid}, 32'd0);
        checkOutput("async rst dec_pc", bus.dec_pc, 32'd0);
        checkOutput("async rst imem_addr", bus.imem_addr, RESET_PC);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'd0);

        // Random traffic, occasionally redirecting near the top of memory
        for (int i = 0; i < 500; i++) begin
            r = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 15) == 0);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            applyStimulus(r, d, t);
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/instr_fetch_buffer.md
INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port imem_addr, output, 32, fetch address to the combinational-read instruction memory; equals the internal PC.
REQ-005 SHALL have port imem_rdata, input, 32, instruction word at imem_addr, valid in the same cycle.
REQ-006 SHALL have port pc_redirect, input, 1, taken branch/jump resolved downstream.
REQ-007 SHALL have port pc_target, input, 32, redirect destination.
REQ-008 SHALL have port dec_ready, input, 1, decode/immediate-extend stage accepts the head entry.
REQ-009 SHALL have port dec_valid, output, 1, head entry is valid.
REQ-010 SHALL have port dec_instr, output, 32, head instruction word, feeding the immediate extender instruction input.
REQ-011 SHALL have port dec_pc, output, 32, PC of the head instruction.
REQ-012 SHALL have port dec_pcplus4, output, 32, dec_pc + 4 modulo 2^32.

Function
REQ-013 SHALL hold a 2-entry FIFO of {instr, pc} plus a 2-bit count (0..2) and a 32-bit PC register.
REQ-014 SHALL define pop = dec_valid & dec_ready and push = !pc_redirect & (count<2 | pop).
REQ-015 SHALL on push write {imem_rdata, pc} at the tail and set pc <= pc + 4, modulo 2^32: 32'hFFFF_FFFC wraps to 0.
REQ-016 SHALL on push without pop increment count, on pop without push decrement it, and on both keep it, with the head advancing and the tail written in the same edge.
REQ-017 SHALL drive dec_valid = (count != 0), and dec_instr/dec_pc from the head entry only; no combinational path from imem_rdata to dec_*.
REQ-018 SHALL give one-cycle fetch latency: a word fetched at edge N is visible on dec_* after edge N.
REQ-019 SHALL when count==2 and !pop hold pc and contents unchanged; imem_addr stays stable.
REQ-020 SHALL on pc_redirect flush: count <= 0, pc <= {pc_target[31:2], 2'b00}, no push, and the pop is discarded even if dec_ready is high.
REQ-021 SHALL make the first post-redirect entry appear one edge after the redirect edge, that is, fetched from the aligned target on the following edge.
REQ-022 SHALL treat dec_instr/dec_pc as don't-care while dec_valid==0; the bench SHALL not check them.

Reset
REQ-023 SHALL on rst asynchronously set pc=RESET_PC, count=0, head/tail pointers=0, dec_valid=0, and FIFO payloads to 0; dec_instr=0, dec_pc=0, and dec_pcplus4=4.
REQ-024 SHALL, when rst asserts mid-operation, discard all entries immediately without waiting for a clock edge; the first push occurs on the first edge with rst low.

Configuration
REQ-025 SHALL, when macro FETCH_STALLCNT_EN is defined, add output stall_cnt [31:0], reset to 0, incremented on each edge where dec_valid & !dec_ready, wrapping at 2^32, and unaffected by redirect.
REQ-026 SHALL, when FETCH_STALLCNT_EN is undefined, omit the stall_cnt port and its logic entirely.

Verification
REQ-027 SHALL cover reset release, RESET_PC=0, dec_ready=1, memory word at address A = A ^ 32'hA5A5_0000: dec_valid rises after edge 1 with dec_pc=0, then dec_pc=4, 8, ... with one entry per cycle.
REQ-028 SHALL cover back-pressure: dec_ready=0 for 5 cycles: count reaches 2, imem_addr frozen at 8, dec_pc held at 0; on dec_ready=1 the outputs are 0, 4, 8 with no gap or duplicate.
REQ-029 SHALL cover redirect with pc_redirect=1, pc_target=32'h0000_0103, FIFO full, dec_ready=1: next cycle dec_valid=0 and imem_addr=32'h100; the following cycle dec_pc=32'h100.
REQ-030 SHALL cover wrap-around: redirect to 32'hFFFF_FFFC: entries dec_pc=32'hFFFF_FFFC with dec_pcplus4=0, then dec_pc=0.
REQ-031 SHALL cover rst pulsed between edges while count==2: dec_valid drops immediately and the next entry after release has dec_pc=RESET_PC.
REQ-032 SHALL cover, with FETCH_STALLCNT_EN defined, dec_ready=0 for 7 edges while dec_valid=1: stall_cnt=7, then holds while dec_ready=1.
